// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam int DEFAULT_DRAIN_CYCLES = 3;

  // Hazard classes, highest priority first: load-use beats halt beats branch.
  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_BRANCH   = 2'd1,
    HZ_HALT     = 2'd2,
    HZ_LOAD_USE = 2'd3
  } hazard_e;

  function automatic hazard_e hazard_pick(input logic load_use,
                                          input logic halt_det,
                                          input logic branch_taken);
    if (load_use) begin
      return HZ_LOAD_USE;
    end else if (halt_det) begin
      return HZ_HALT;
    end else if (branch_taken) begin
      return HZ_BRANCH;
    end else begin
      return HZ_NONE;
    end
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_r;

  // Count enabled cycles, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else if (en && (count_r != {CNT_WIDTH{1'b1}})) begin
      count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: debug run/step/pause, hazard overrides and
// HALT drain for the 5-stage core's PC and pipeline registers.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_run,
  input  logic                 i_step,
  input  logic                 i_pause,
  input  logic                 i_halt_det,
  input  logic                 i_load_use,
  input  logic                 i_branch_taken,
  output logic                 o_pc_en,
  output logic                 o_if_id_en,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_en,
  output logic                 o_id_ex_flush,
  output logic                 o_ex_mem_en,
  output logic                 o_mem_wb_en,
  output logic                 o_busy,
  output logic                 o_halted,
  output logic [CNT_WIDTH-1:0] o_cycle_cnt
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

  state_e     state_r;
  state_e     state_next_s;
  logic [2:0] drain_r;
  logic       busy_r;
  logic       halted_r;
  hazard_e    hz_s;
  logic       advance_s;

  assign hz_s      = hazard_pick(i_load_use, i_halt_det, i_branch_taken);
  assign advance_s = (state_r == ST_RUN) || (state_r == ST_STEP) || (state_r == ST_DRAIN);

  // Next-state selection; a stalled HALT is not yet seen, so it cannot start a drain.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_run) begin
          state_next_s = ST_RUN;
        end else if (i_step) begin
          state_next_s = ST_STEP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hz_s == HZ_HALT) begin
          state_next_s = ST_DRAIN;
        end else if (i_pause) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_STEP: begin
        if (hz_s == HZ_HALT) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_r == 3'd1) begin
          state_next_s = ST_HALTED;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_HALTED: state_next_s = ST_HALTED;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State, drain counter and status flags.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      drain_r  <= 3'd0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      busy_r   <= (state_next_s == ST_RUN) || (state_next_s == ST_STEP) ||
                  (state_next_s == ST_DRAIN);
      halted_r <= (state_next_s == ST_HALTED);
      if ((state_r != ST_DRAIN) && (state_next_s == ST_DRAIN)) begin
        drain_r <= DRAIN_LOAD;
      end else if ((state_r == ST_DRAIN) && (drain_r != 3'd0)) begin
        drain_r <= drain_r - 3'd1;
      end else begin
        drain_r <= drain_r;
      end
    end
  end

  // Stage strobes from the current state and live hazard inputs.
  always_comb begin
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_en    = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    case (state_r)
      ST_RUN, ST_STEP: begin
        o_pc_en     = 1'b1;
        o_if_id_en  = 1'b1;
        o_id_ex_en  = 1'b1;
        o_ex_mem_en = 1'b1;
        o_mem_wb_en = 1'b1;
        case (hz_s)
          HZ_LOAD_USE: begin
            o_pc_en       = 1'b0;
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
          end
          HZ_HALT: begin
            o_pc_en    = 1'b0;
            o_if_id_en = 1'b0;
          end
          HZ_BRANCH: o_if_id_flush = 1'b1;
          default:   o_if_id_flush = 1'b0;
        endcase
      end
      // Front end frozen; bubbles enter ID/EX while older work retires.
      ST_DRAIN: begin
        o_id_ex_en    = 1'b1;
        o_id_ex_flush = 1'b1;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
      end
      default: o_pc_en = 1'b0;
    endcase
  end

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cycle_cnt (
    .clk  (clk),
    .rst  (i_rst),
    .en   (advance_s),
    .count(o_cycle_cnt)
  );

  assign o_busy   = busy_r;
  assign o_halted = halted_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (4-bit cycle counter, 3-cycle drain).
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_run = 1'b0;
  logic       i_step = 1'b0;
  logic       i_pause = 1'b0;
  logic       i_halt_det = 1'b0;
  logic       i_load_use = 1'b0;
  logic       i_branch_taken = 1'b0;
  logic       o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush;
  logic       o_ex_mem_en, o_mem_wb_en, o_busy, o_halted;
  logic [3:0] o_cycle_cnt;
  logic [6:0] en_s;

  int pass_cnt = 0;
  int check_cnt = 0;

  // {pc, if_id, if_id_flush, id_ex, id_ex_flush, ex_mem, mem_wb}
  localparam logic [6:0] EN_OFF   = 7'b0000000;
  localparam logic [6:0] EN_ALL   = 7'b1101011;
  localparam logic [6:0] EN_STALL = 7'b0001111;
  localparam logic [6:0] EN_BR    = 7'b1111011;
  localparam logic [6:0] EN_HALT  = 7'b0001011;
  localparam logic [6:0] DRAIN_MASK = 7'b1110111;
  localparam logic [6:0] EN_DRAIN = 7'b0000111;

  pipeline_ctrl #(
    .DRAIN_CYCLES(3),
    .CNT_WIDTH   (4)
  ) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_run         (i_run),
    .i_step        (i_step),
    .i_pause       (i_pause),
    .i_halt_det    (i_halt_det),
    .i_load_use    (i_load_use),
    .i_branch_taken(i_branch_taken),
    .o_pc_en       (o_pc_en),
    .o_if_id_en    (o_if_id_en),
    .o_if_id_flush (o_if_id_flush),
    .o_id_ex_en    (o_id_ex_en),
    .o_id_ex_flush (o_id_ex_flush),
    .o_ex_mem_en   (o_ex_mem_en),
    .o_mem_wb_en   (o_mem_wb_en),
    .o_busy        (o_busy),
    .o_halted      (o_halted),
    .o_cycle_cnt   (o_cycle_cnt)
  );

  assign en_s = {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
                 o_ex_mem_en, o_mem_wb_en};

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cyc();
    cyc();
    i_rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset_en", 16'(en_s), 16'(EN_OFF));
    chk("reset_busy", 16'(o_busy), 16'd0);
    chk("reset_halted", 16'(o_halted), 16'd0);
    chk("reset_cnt", 16'(o_cycle_cnt), 16'd0);

    // Single step: one advance cycle then back to IDLE
    i_step = 1'b1;
    cyc();
    i_step = 1'b0;
    #1;
    chk("step_en", 16'(en_s), 16'(EN_ALL));
    chk("step_busy", 16'(o_busy), 16'd1);
    cyc();
    #1;
    chk("step_done_en", 16'(en_s), 16'(EN_OFF));
    chk("step_done_busy", 16'(o_busy), 16'd0);
    chk("step_cnt", 16'(o_cycle_cnt), 16'd1);

    // RUN with hazards
    i_run = 1'b1;
    cyc();
    i_run = 1'b0;
    i_load_use = 1'b1;
    #1;
    chk("load_use_en", 16'(en_s), 16'(EN_STALL));
    cyc();
    i_branch_taken = 1'b1;
    #1;
    chk("lu_plus_branch_en", 16'(en_s), 16'(EN_STALL));
    cyc();
    i_load_use = 1'b0;
    #1;
    chk("branch_en", 16'(en_s), 16'(EN_BR));
    cyc();
    i_branch_taken = 1'b0;
    #1;
    chk("after_stall_en", 16'(en_s), 16'(EN_ALL));
    chk("run_cnt", 16'(o_cycle_cnt), 16'd4);

    // HALT together with pause: drain wins over IDLE
    i_halt_det = 1'b1;
    i_pause = 1'b1;
    #1;
    chk("halt_en", 16'(en_s), 16'(EN_HALT));
    cyc();
    i_halt_det = 1'b0;
    i_pause = 1'b0;
    #1;
    chk("halt_pause_busy", 16'(o_busy), 16'd1);
    chk("drain_en", 16'(en_s & DRAIN_MASK), 16'(EN_DRAIN));
    cyc();
    cyc();
    chk("drain3_halted", 16'(o_halted), 16'd0);
    cyc();
    chk("halted", 16'(o_halted), 16'd1);
    chk("halted_busy", 16'(o_busy), 16'd0);
    chk("halted_en", 16'(en_s), 16'(EN_OFF));
    chk("halted_cnt", 16'(o_cycle_cnt), 16'd8);
    i_run = 1'b1;
    cyc();
    i_run = 1'b0;
    cyc();
    chk("halted_run_ignored", 16'(o_halted), 16'd1);
    chk("halted_run_en", 16'(en_s), 16'(EN_OFF));

    // Halt in RUN cycle 10: drain cycles 11..13, halted in 14 after 13 advance cycles
    do_reset();
    i_run = 1'b1;
    cyc();
    i_run = 1'b0;
    repeat (9) cyc();
    i_halt_det = 1'b1;
    #1;
    chk("c10_halt_en", 16'(en_s), 16'(EN_HALT));
    cyc();
    i_halt_det = 1'b0;
    #1;
    chk("c11_drain_busy", 16'(o_busy), 16'd1);
    cyc();
    cyc();
    chk("c13_not_halted", 16'(o_halted), 16'd0);
    cyc();
    chk("c14_halted", 16'(o_halted), 16'd1);
    chk("c14_cnt", 16'(o_cycle_cnt), 16'd13);

    // Pause ends RUN; run+step together picks RUN
    do_reset();
    i_run = 1'b1;
    cyc();
    i_run = 1'b0;
    i_pause = 1'b1;
    #1;
    chk("pause_cycle_en", 16'(en_s), 16'(EN_ALL));
    cyc();
    i_pause = 1'b0;
    #1;
    chk("paused_en", 16'(en_s), 16'(EN_OFF));
    chk("paused_busy", 16'(o_busy), 16'd0);
    i_run = 1'b1;
    i_step = 1'b1;
    cyc();
    i_run = 1'b0;
    i_step = 1'b0;
    cyc();
    chk("run_prio_en", 16'(en_s), 16'(EN_ALL));
    chk("run_prio_busy", 16'(o_busy), 16'd1);

    // Saturation at 15, then reset in the middle of a drain
    do_reset();
    i_run = 1'b1;
    cyc();
    i_run = 1'b0;
    repeat (20) cyc();
    chk("sat_cnt", 16'(o_cycle_cnt), 16'd15);
    i_halt_det = 1'b1;
    cyc();
    i_halt_det = 1'b0;
    #1;
    chk("pre_rst_drain", 16'(en_s & DRAIN_MASK), 16'(EN_DRAIN));
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    #1;
    chk("rst_drain_en", 16'(en_s), 16'(EN_OFF));
    chk("rst_drain_cnt", 16'(o_cycle_cnt), 16'd0);
    chk("rst_drain_busy", 16'(o_busy), 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
